// File: rtl/apb_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_stream_pkg
// Description : Shared types and constants for the APB stream writer:
//               - the FSM state enum
//               - the APB address width and word size
//               - the word-index to byte-address helper
// Revision    : 1.0 - initial release
// ============================================================================
package apb_stream_pkg;

  localparam int APB_AW     = 20;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    RSETUP  = 3'd3,
    RACCESS = 3'd4
  } state_t;

  // Byte address of frame word idx; the result wraps within the APB address space.
  function automatic logic [APB_AW-1:0] word_addr(input logic [APB_AW-1:0] base,
                                                  input logic [15:0]       idx);
    logic [APB_AW-1:0] off;
    off = APB_AW'(APB_AW'(idx) * WORD_BYTES);
    return base + off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : apb_stream_fifo
// Description : Synchronous FIFO holding {last, data} stream entries.
//   clk, rst_n   : clock, synchronous active-low reset (resets to empty)
//   push/push_data : write request; ignored when full
//   pop          : read request; ignored when empty
//   head/second  : oldest entry and the one behind it
//   full/empty   : occupancy flags; multi = at least two entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module apb_stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2     // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] second,
  output logic             full,
  output logic             empty,
  output logic             multi
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;
  logic [PW-1:0]    rd_next;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_next = rd_ptr + 1'b1;

  // DEPTH is a power of two, so the count MSB alone marks "full".
  assign full   = cnt[PW];
  assign empty  = (cnt == '0);
  assign multi  = (cnt > {{PW{1'b0}}, 1'b1});
  assign head   = mem[rd_ptr];
  assign second = mem[rd_next];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/apb_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : apb_stream_writer
// Description : APB3 master that drains a 32-bit word stream into an APB SRAM,
//               one frame per pass starting at BASE_ADDR.
//   PCLK, PRESETN                : clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last: input word stream
//   PSEL..PSLVERR                : APB3 master port (20-bit byte address)
//   frame_done, frame_words      : frame completion pulse and word count
//   overflow, slv_err, verify_err: sticky error flags, cleared by err_clr
// Build option: define APB_STREAM_WRITER_VERIFY_EN to read back every word
//               after writing it and flag mismatches on verify_err.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_stream_writer
  import apb_stream_pkg::*;
#(
  parameter int                 APB_DWIDTH = 32,        // only 32 supported
  parameter logic [APB_AW-1:0]  BASE_ADDR  = 20'h00000, // must be 4-aligned
  parameter int                 DEPTH      = 512,       // frame capacity in words
  parameter int                 FIFO_DEPTH = 2          // power of two, >= 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [APB_DWIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_AW-1:0]     PADDR,
  output logic [APB_DWIDTH-1:0] PWDATA,
  input  logic [APB_DWIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  frame_done,
  output logic [15:0]           frame_words,
  output logic                  overflow,
  output logic                  slv_err,
  output logic                  verify_err,
  input  logic                  err_clr
);

  state_t                state_q, state_d;
  logic [15:0]           idx_q, idx_next;
  logic [APB_AW-1:0]     paddr_q;
  logic [APB_DWIDTH-1:0] pwdata_q;
  logic                  frame_done_q, overflow_q, slv_err_q;
  logic [15:0]           frame_words_q;

  logic [APB_DWIDTH:0]   fifo_head, fifo_second;
  logic                  fifo_full, fifo_empty, fifo_multi;
  logic                  push, head_last, wrap;
  logic                  load, load_next, retire, xfer_done;
  logic                  unused_second_last;

  assign s_ready            = PRESETN & ~fifo_full;
  assign push               = s_valid & s_ready;
  assign head_last          = fifo_head[APB_DWIDTH];
  assign unused_second_last = fifo_second[APB_DWIDTH];

  apb_stream_fifo #(
    .WIDTH (APB_DWIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETN),
    .push      (push),
    .push_data ({s_last, s_data}),
    .pop       (retire),
    .head      (fifo_head),
    .second    (fifo_second),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .multi     (fifo_multi)
  );

  // Index of the word after the head retires; a non-last word at the end of
  // the frame buffer wraps to 0 and flags overflow.
  always_comb begin
    idx_next = idx_q + 16'd1;
    wrap     = 1'b0;
    if (head_last) begin
      idx_next = '0;
    end else if (idx_q == 16'(DEPTH - 1)) begin
      idx_next = '0;
      wrap     = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_next = 1'b0;
    retire    = 1'b0;
    xfer_done = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        if (PREADY) begin
          xfer_done = 1'b1;
`ifdef APB_STREAM_WRITER_VERIFY_EN
          state_d   = RSETUP;
`else
          retire    = 1'b1;
`endif
        end
      end
`ifdef APB_STREAM_WRITER_VERIFY_EN
      RSETUP: begin
        PSEL    = 1'b1;
        state_d = RACCESS;
      end
      RACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          xfer_done = 1'b1;
          retire    = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // The retiring word is still the head, so the next word is the second entry.
    if (retire) begin
      load_next = fifo_multi;
      state_d   = fifo_multi ? SETUP : IDLE;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      frame_done_q  <= 1'b0;
      frame_words_q <= '0;
      overflow_q    <= 1'b0;
      slv_err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        paddr_q  <= word_addr(BASE_ADDR, idx_q);
        pwdata_q <= fifo_head[APB_DWIDTH-1:0];
      end else if (load_next) begin
        paddr_q  <= word_addr(BASE_ADDR, idx_next);
        pwdata_q <= fifo_second[APB_DWIDTH-1:0];
      end
      frame_done_q <= retire & head_last;
      if (retire) begin
        idx_q <= idx_next;
        if (head_last) frame_words_q <= idx_q + 16'd1;
      end
      if (retire && wrap)        overflow_q <= 1'b1;
      else if (err_clr)          overflow_q <= 1'b0;
      if (xfer_done && PSLVERR)  slv_err_q  <= 1'b1;
      else if (err_clr)          slv_err_q  <= 1'b0;
    end
  end

`ifdef APB_STREAM_WRITER_VERIFY_EN
  logic verify_err_q;
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      verify_err_q <= 1'b0;
    end else if (state_q == RACCESS && PREADY && PRDATA != pwdata_q) begin
      verify_err_q <= 1'b1;
    end else if (err_clr) begin
      verify_err_q <= 1'b0;
    end
  end
  assign verify_err = verify_err_q;
`else
  logic unused_prdata;
  assign unused_prdata = ^PRDATA;
  assign verify_err    = 1'b0;
`endif

  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign frame_done  = frame_done_q;
  assign frame_words = frame_words_q;
  assign overflow    = overflow_q;
  assign slv_err     = slv_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_stream_writer
// Description : Self-checking bench for apb_stream_writer with an APB slave
//               model, a transfer monitor and a frame-level reference model.
//               Honours APB_STREAM_WRITER_VERIFY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb_stream_writer;

  localparam int          DEPTH = 4;
  localparam logic [19:0] BASE  = 20'h00040;
`ifdef APB_STREAM_WRITER_VERIFY_EN
  localparam int CPW = 4;   // cycles per word back to back
  localparam int LAT = 6;   // accept to frame_done
  localparam bit VERIFY = 1'b1;
`else
  localparam int CPW = 2;
  localparam int LAT = 4;
  localparam bit VERIFY = 1'b0;
`endif

  logic        PCLK = 1'b0, PRESETN = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, err_clr = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, PSEL, PENABLE, PWRITE, frame_done, overflow, slv_err, verify_err;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b1, PSLVERR = 1'b0;
  logic [15:0] frame_words;

  int n_checks = 0, n_fail = 0;

  apb_stream_writer #(.APB_DWIDTH(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .FIFO_DEPTH(2)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .frame_done(frame_done), .frame_words(frame_words), .overflow(overflow),
    .slv_err(slv_err), .verify_err(verify_err), .err_clr(err_clr));

  always #5 PCLK = ~PCLK;

  // ---------------- APB slave model ----------------
  int          wait_mode = 0;            // 0 none, 1 random 0..2, 2 stall one address
  logic [19:0] stall_addr = '0;
  int          stall_len = 0;
  bit          err_en = 0, corrupt_en = 0;
  logic [19:0] err_addr = '0, corrupt_addr = '0;
  logic [31:0] mem [int];
  int          acc_cnt = 0, wait_req = 0;

  always @(posedge PCLK) begin
    #1;
    if (PSEL && !PENABLE) begin
      acc_cnt = 0;
      if (wait_mode == 1)                                   wait_req = $urandom_range(0, 2);
      else if (wait_mode == 2 && PWRITE && PADDR == stall_addr) wait_req = stall_len;
      else                                                  wait_req = 0;
    end else if (PSEL && PENABLE) begin
      acc_cnt++;
    end
    PREADY  = !(PSEL && PENABLE) || (acc_cnt > wait_req);
    PSLVERR = PSEL && PENABLE && PWRITE && err_en && (PADDR == err_addr);
    if (corrupt_en && PADDR == corrupt_addr) PRDATA = 32'h0000DEAD;
    else if (mem.exists(int'(PADDR)))        PRDATA = mem[int'(PADDR)];
    else                                     PRDATA = '0;
  end

  // ---------------- monitor ----------------
  int          cyc = 0, fd_cnt = 0, n_reads = 0, acc_len = 0;
  bit          saw_not_ready = 0;
  logic [19:0] su_addr;
  logic [31:0] su_data;
  logic        su_wr;
  logic [19:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wcyc_q[$];
  int          alen_q[$];

  always @(negedge PCLK) begin
    cyc++;
    if (PRESETN && !s_ready) saw_not_ready = 1;
    if (frame_done) fd_cnt++;
    if (PSEL && !PENABLE) begin
      su_addr = PADDR; su_data = PWDATA; su_wr = PWRITE; acc_len = 0;
    end
    if (PSEL && PENABLE) begin
      acc_len++;
      n_checks++;
      if (PADDR !== su_addr || PWRITE !== su_wr || (su_wr && PWDATA !== su_data)) begin
        n_fail++;
        $display("FAIL apb_stable: addr=%h wr=%b data=%h, setup had addr=%h wr=%b data=%h",
                 PADDR, PWRITE, PWDATA, su_addr, su_wr, su_data);
      end
      if (PREADY) begin
        if (PWRITE) begin
          wa_q.push_back(PADDR); wd_q.push_back(PWDATA);
          wcyc_q.push_back(cyc); alen_q.push_back(acc_len);
          mem[int'(PADDR)] = PWDATA;
        end else begin
          n_reads++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] fw[$];   // words of the frame being sent

  task automatic tick();
    @(negedge PCLK); #1;
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wcyc_q.delete(); alen_q.delete();
    n_reads = 0; saw_not_ready = 0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic send_frame(output bit ok);
    int k;
    ok = 1;
    for (int i = 0; i < fw.size(); i++) begin
      s_valid = 1'b1; s_data = fw[i]; s_last = (i == fw.size() - 1);
      k = 0;
      while (!s_ready && k < 300) begin tick(); k++; end
      if (!s_ready) begin ok = 0; break; end
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_fd(input int target, output bit ok);
    int k = 0;
    while (fd_cnt < target && k < 400) begin tick(); k++; end
    ok = (fd_cnt >= target);
    repeat (4) tick();   // let any stray extra pulse show up
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, s_ready, frame_done, overflow, slv_err, verify_err} !== 8'h00 ||
        PADDR !== 20'h0 || PWDATA !== 32'h0 || frame_words !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_values: psel=%b pen=%b pwr=%b rdy=%b fd=%b ov=%b se=%b ve=%b paddr=%h pwdata=%h fw=%0d, required all 0",
               PSEL, PENABLE, PWRITE, s_ready, frame_done, overflow, slv_err, verify_err, PADDR, PWDATA, frame_words);
    end
    PRESETN = 1'b1;
    tick();
    n_checks++;
    if (s_ready !== 1'b1 || PSEL !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: s_ready=%b psel=%b, required 1 0", s_ready, PSEL);
    end
  endtask

  task automatic test_basic_frame();
    bit ok, ok2; int fd0;
    clear_log(); wait_mode = 0; fd0 = fd_cnt;
    fw = '{32'hA0, 32'hA1, 32'hA2};
    send_frame(ok); wait_fd(fd0 + 1, ok2);
    n_checks++;
    if (!ok || !ok2 || fd_cnt != fd0 + 1) begin
      n_fail++; $display("FAIL basic_done: frame_done pulses=%0d, required 1", fd_cnt - fd0);
    end
    n_checks++;
    if (wa_q.size() != 3 || wa_q[0] !== BASE || wa_q[1] !== BASE + 20'h4 || wa_q[2] !== BASE + 20'h8 ||
        wd_q[0] !== 32'hA0 || wd_q[1] !== 32'hA1 || wd_q[2] !== 32'hA2) begin
      n_fail++; $display("FAIL basic_writes: %0d writes first addr=%h, required 3 writes from %h", wa_q.size(),
                         (wa_q.size() > 0) ? wa_q[0] : 20'hFFFFF, BASE);
    end
    n_checks++;
    if (frame_words !== 16'd3 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL basic_words: frame_words=%0d overflow=%b, required 3 0", frame_words, overflow);
    end
  endtask

  task automatic test_latency();
    int first_fd = -1;
    clear_log(); wait_mode = 0;
    s_valid = 1'b1; s_data = 32'h55; s_last = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      tick();
      if (c == 1) begin s_valid = 1'b0; s_last = 1'b0; end
      if (frame_done && first_fd < 0) first_fd = c;
    end
    n_checks++;
    if (first_fd != LAT) begin
      n_fail++; $display("FAIL latency: frame_done at cycle n+%0d, required n+%0d", first_fd, LAT);
    end
    n_checks++;
    if (frame_words !== 16'd1) begin
      n_fail++; $display("FAIL single_word: frame_words=%0d, required 1", frame_words);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2; int fd0; int bad = 0;
    clear_log(); wait_mode = 0; fd0 = fd_cnt;
    fw = '{32'h10, 32'h11, 32'h12, 32'h13};
    send_frame(ok); wait_fd(fd0 + 1, ok2);
    for (int i = 1; i < wcyc_q.size(); i++) if (wcyc_q[i] - wcyc_q[i-1] != CPW) bad++;
    n_checks++;
    if (!ok || !ok2 || wcyc_q.size() != 4 || bad != 0) begin
      n_fail++; $display("FAIL back_to_back: %0d writes, %0d gaps not %0d cycles", wcyc_q.size(), bad, CPW);
    end
    n_checks++;
    if (frame_words !== 16'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_frame: frame_words=%0d overflow=%b, required 4 0", frame_words, overflow);
    end
  endtask

  task automatic test_stall();
    bit ok, ok2; int fd0;
    clear_log(); fd0 = fd_cnt;
    wait_mode = 2; stall_addr = BASE + 20'h4; stall_len = 2;
    fw = '{32'hA0, 32'hA1, 32'hA2};
    send_frame(ok); wait_fd(fd0 + 1, ok2);
    n_checks++;
    if (!ok || !ok2 || alen_q.size() != 3 || alen_q[1] != 3 || alen_q[0] != 1 || wd_q[1] !== 32'hA1) begin
      n_fail++; $display("FAIL stall_access: word1 access cycles=%0d, required 3",
                         (alen_q.size() > 1) ? alen_q[1] : -1);
    end
    n_checks++;
    if (saw_not_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_ready: s_ready low seen=%b, required 1", saw_not_ready);
    end
    wait_mode = 0;
  endtask

  task automatic test_overflow();
    bit ok, ok2; int fd0;
    clear_log(); wait_mode = 0; fd0 = fd_cnt;
    fw = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
    send_frame(ok); wait_fd(fd0 + 1, ok2);
    n_checks++;
    if (!ok || !ok2 || overflow !== 1'b1 || frame_words !== 16'd2) begin
      n_fail++; $display("FAIL overflow_set: overflow=%b frame_words=%0d, required 1 2", overflow, frame_words);
    end
    n_checks++;
    if (wa_q.size() != 6 || wa_q[5] !== BASE + 20'h4 || wd_q[5] !== 32'hB5 || wa_q[4] !== BASE) begin
      n_fail++; $display("FAIL overflow_wrap: last write addr=%h, required %h",
                         (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 20'hFFFFF, BASE + 20'h4);
    end
    pulse_clr();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL overflow_clr: overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_slverr();
    bit ok, ok2; int fd0;
    clear_log(); wait_mode = 0; fd0 = fd_cnt;
    err_en = 1; err_addr = BASE;
    fw = '{32'hC0, 32'hC1};
    send_frame(ok); wait_fd(fd0 + 1, ok2);
    err_en = 0;
    n_checks++;
    if (!ok || !ok2 || slv_err !== 1'b1 || frame_words !== 16'd2 || wa_q.size() != 2) begin
      n_fail++; $display("FAIL slverr: slv_err=%b frame_words=%0d writes=%0d, required 1 2 2",
                         slv_err, frame_words, wa_q.size());
    end
    pulse_clr();
    n_checks++;
    if (slv_err !== 1'b0) begin
      n_fail++; $display("FAIL slverr_clr: slv_err=%b, required 0", slv_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2; int fd0; int k = 0;
    clear_log(); fd0 = fd_cnt;
    wait_mode = 2; stall_addr = BASE + 20'h4; stall_len = 6;
    fw = '{32'hD0, 32'hD1, 32'hD2};
    send_frame(ok);
    while (!(PSEL && PENABLE && PADDR == BASE + 20'h4) && k < 50) begin tick(); k++; end
    PRESETN = 1'b0;
    tick();
    n_checks++;
    if (!ok || k >= 50 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_apb: psel=%b penable=%b, required 0 0", PSEL, PENABLE);
    end
    tick(); PRESETN = 1'b1; wait_mode = 0;
    clear_log();
    repeat (6) tick();
    n_checks++;
    if (fd_cnt != fd0 || wa_q.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_flush: frame_done pulses=%0d writes=%0d, required 0 0",
                         fd_cnt - fd0, wa_q.size());
    end
    fw = '{32'hE0, 32'hE1};
    send_frame(ok); wait_fd(fd0 + 1, ok2);
    n_checks++;
    if (!ok || !ok2 || wa_q.size() != 2 || wa_q[0] !== BASE || frame_words !== 16'd2) begin
      n_fail++; $display("FAIL reset_mid_restart: first addr=%h frame_words=%0d, required %h 2",
                         (wa_q.size() > 0) ? wa_q[0] : 20'hFFFFF, frame_words, BASE);
    end
  endtask

  task automatic test_verify();
    bit ok, ok2; int fd0;
    clear_log(); wait_mode = 0; fd0 = fd_cnt;
    corrupt_en = 1; corrupt_addr = BASE;
    fw = '{32'hF0, 32'hF1};
    send_frame(ok); wait_fd(fd0 + 1, ok2);
    corrupt_en = 0;
    n_checks++;
    if (!ok || !ok2 || verify_err !== VERIFY || n_reads != (VERIFY ? 2 : 0)) begin
      n_fail++; $display("FAIL verify_bad: verify_err=%b reads=%0d, required %b %0d",
                         verify_err, n_reads, VERIFY, VERIFY ? 2 : 0);
    end
    pulse_clr(); clear_log(); fd0 = fd_cnt;
    send_frame(ok); wait_fd(fd0 + 1, ok2);
    n_checks++;
    if (!ok || !ok2 || verify_err !== 1'b0) begin
      n_fail++; $display("FAIL verify_good: verify_err=%b, required 0", verify_err);
    end
  endtask

  // Frame-level model: word i lands at BASE + 4*(i mod DEPTH).
  task automatic test_random();
    bit ok, ok2; int fd0, n, bad, exp_fw;
    wait_mode = 1;
    for (int f = 0; f < 8; f++) begin
      pulse_clr(); clear_log(); fd0 = fd_cnt;
      n = $urandom_range(1, 2 * DEPTH - 1);
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back($urandom);
      send_frame(ok); wait_fd(fd0 + 1, ok2);
      bad = 0;
      if (wa_q.size() != n) bad++;
      else for (int i = 0; i < n; i++)
        if (wa_q[i] !== BASE + 20'(4 * (i % DEPTH)) || wd_q[i] !== fw[i]) bad++;
      exp_fw = ((n - 1) % DEPTH) + 1;
      n_checks++;
      if (!ok || !ok2 || bad != 0 || fd_cnt != fd0 + 1) begin
        n_fail++; $display("FAIL random_writes frame %0d: len=%0d writes=%0d wrong=%0d pulses=%0d",
                           f, n, wa_q.size(), bad, fd_cnt - fd0);
      end
      n_checks++;
      if (frame_words !== 16'(exp_fw) || overflow !== (n > DEPTH) || verify_err !== 1'b0) begin
        n_fail++; $display("FAIL random_status frame %0d: frame_words=%0d overflow=%b, required %0d %b",
                           f, frame_words, overflow, exp_fw, (n > DEPTH));
      end
    end
    wait_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_latency();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_slverr();
    test_reset_mid();
    test_verify();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
